// File: rtl/countdown_timer.sv
// Countdown timer: the switch/button interface presets hh:mm:ss, then the count decrements on each 1 Hz tick.
// At 00:00:00 the alarm is raised until it is acknowledged or ALARM_TICKS ticks have elapsed.
module countdown_timer #(
    parameter int MAX_HOUR    = 23,
    parameter int ALARM_TICKS = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_timer,
    input  logic       set_timer,
    input  logic [4:0] sw,
    output logic       running,
    output logic       alarm,
    output logic [1:0] field_sel,
    output logic [7:0] bcd_timer_hour,
    output logic [7:0] bcd_timer_min,
    output logic [7:0] bcd_timer_sec
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    localparam int         CW   = $clog2(ALARM_TICKS + 1);
    localparam logic [5:0] HMAX = 6'(MAX_HOUR);

    state_t          r_state;
    logic [5:0]      r_hour, r_min, r_sec;
    logic [5:0]      r_pre_hour, r_pre_min, r_pre_sec;
    logic [1:0]      r_field;
    logic [CW-1:0]   r_acnt;
    logic            r_running, r_alarm;

    logic [5:0]      w_sel_val, w_sel_max, w_inc, w_dec;
    logic            w_zero, w_last;

    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [7:0] b;
        b = {2'b00, v};
        return ((b / 8'd10) << 4) | (b % 8'd10);
    endfunction

    always_comb begin
        w_sel_val = r_hour;
        w_sel_max = HMAX;
        case (r_field)
            2'd0: begin w_sel_val = r_sec; w_sel_max = 6'd59; end
            2'd1: begin w_sel_val = r_min; w_sel_max = 6'd59; end
            default: ;
        endcase
        w_inc  = (w_sel_val == w_sel_max) ? 6'd0 : w_sel_val + 6'd1;
        w_dec  = (w_sel_val == 6'd0) ? w_sel_max : w_sel_val - 6'd1;
        w_zero = (r_hour == 6'd0) && (r_min == 6'd0) && (r_sec == 6'd0);
        // The tick that consumes the last second is the one that enters DONE.
        w_last = (r_hour == 6'd0) && (r_min == 6'd0) && (r_sec == 6'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_hour     <= '0;
            r_min      <= '0;
            r_sec      <= '0;
            r_pre_hour <= '0;
            r_pre_min  <= '0;
            r_pre_sec  <= '0;
            r_field    <= '0;
            r_acnt     <= '0;
            r_running  <= 1'b0;
            r_alarm    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (set_timer) begin
                    if (sw[2]) begin
                        r_hour <= '0;
                        r_min  <= '0;
                        r_sec  <= '0;
                    end else if (sw[1]) begin
                        if (!w_zero) begin
                            r_pre_hour <= r_hour;
                            r_pre_min  <= r_min;
                            r_pre_sec  <= r_sec;
                            r_state    <= S_RUN;
                            r_running  <= 1'b1;
                        end
                    end else if (sw[3] || sw[4]) begin
                        case (r_field)
                            2'd0:    r_sec  <= sw[3] ? w_inc : w_dec;
                            2'd1:    r_min  <= sw[3] ? w_inc : w_dec;
                            default: r_hour <= sw[3] ? w_inc : w_dec;
                        endcase
                    end else if (sw[0]) begin
                        r_field <= (r_field == 2'd2) ? 2'd0 : r_field + 2'd1;
                    end
                end
                S_RUN, S_PAUSE: begin
                    if (set_timer && sw[2]) begin
                        r_hour    <= '0;
                        r_min     <= '0;
                        r_sec     <= '0;
                        r_field   <= '0;
                        r_state   <= S_IDLE;
                        r_running <= 1'b0;
                    end else if (set_timer && sw[1]) begin
                        r_state   <= (r_state == S_RUN) ? S_PAUSE : S_RUN;
                        r_running <= (r_state == S_PAUSE);
                    end else if (en_timer && r_state == S_RUN) begin
                        if (r_sec != 6'd0) begin
                            r_sec <= r_sec - 6'd1;
                        end else if (r_min != 6'd0) begin
                            r_sec <= 6'd59;
                            r_min <= r_min - 6'd1;
                        end else begin
                            r_sec  <= 6'd59;
                            r_min  <= 6'd59;
                            r_hour <= r_hour - 6'd1;
                        end
                        if (w_last) begin
                            r_state   <= S_DONE;
                            r_running <= 1'b0;
                            r_alarm   <= 1'b1;
                            r_acnt    <= '0;
                        end
                    end
                end
                S_DONE: begin
                    // Any acknowledging command is consumed here and never reaches the edit logic.
                    if ((set_timer && (sw != 5'd0)) ||
                        (en_timer && r_acnt == CW'(ALARM_TICKS - 1))) begin
                        r_hour  <= r_pre_hour;
                        r_min   <= r_pre_min;
                        r_sec   <= r_pre_sec;
                        r_field <= '0;
                        r_acnt  <= '0;
                        r_alarm <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (en_timer) begin
                        r_acnt <= r_acnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign running        = r_running;
    assign alarm          = r_alarm;
    assign field_sel      = r_field;
    assign bcd_timer_hour = to_bcd(r_hour);
    assign bcd_timer_min  = to_bcd(r_min);
    assign bcd_timer_sec  = to_bcd(r_sec);

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: a table of single-cycle edit vectors followed by
// hand-written sequences for run, pause, alarm timeout, acknowledgement and async reset.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_timer;
    logic       set_timer;
    logic [4:0] sw;
    logic       running;
    logic       alarm;
    logic [1:0] field_sel;
    logic [7:0] bcd_timer_hour, bcd_timer_min, bcd_timer_sec;

    localparam logic [4:0] SW_NONE = 5'b00000;
    localparam logic [4:0] SW_NEXT = 5'b00001;
    localparam logic [4:0] SW_SS   = 5'b00010;
    localparam logic [4:0] SW_CLR  = 5'b00100;
    localparam logic [4:0] SW_INC  = 5'b01000;
    localparam logic [4:0] SW_DEC  = 5'b10000;

    countdown_timer #(.MAX_HOUR(23), .ALARM_TICKS(30)) dut (
        .clk            (clk),
        .rst            (rst),
        .en_timer       (en_timer),
        .set_timer      (set_timer),
        .sw             (sw),
        .running        (running),
        .alarm          (alarm),
        .field_sel      (field_sel),
        .bcd_timer_hour (bcd_timer_hour),
        .bcd_timer_min  (bcd_timer_min),
        .bcd_timer_sec  (bcd_timer_sec)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       set;
        logic       en;
        logic [4:0] sw;
        logic       run;
        logic       alm;
        logic [1:0] fs;
        logic [7:0] h;
        logic [7:0] m;
        logic [7:0] s;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic r, input logic a, input logic [1:0] f,
                           input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        chk({tag, ".running"},   32'(running),        32'(r));
        chk({tag, ".alarm"},     32'(alarm),          32'(a));
        chk({tag, ".field_sel"}, 32'(field_sel),      32'(f));
        chk({tag, ".hour"},      32'(bcd_timer_hour), 32'(h));
        chk({tag, ".min"},       32'(bcd_timer_min),  32'(m));
        chk({tag, ".sec"},       32'(bcd_timer_sec),  32'(s));
    endtask

    task automatic step(input logic set, input logic en, input logic [4:0] s);
        @(negedge clk);
        set_timer = set;
        en_timer  = en;
        sw        = s;
        @(posedge clk);
        #1;
        set_timer = 1'b0;
        en_timer  = 1'b0;
        sw        = SW_NONE;
    endtask

    task automatic cmd(input logic [4:0] s);
        step(1'b1, 1'b0, s);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, SW_NONE);
    endtask

    initial begin
        rst       = 1'b1;
        en_timer  = 1'b0;
        set_timer = 1'b0;
        sw        = SW_NONE;

        //            set   en    sw                 run   alm   fs     hour   min    sec
        vt.push_back('{1'b1, 1'b0, SW_INC,           1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h01});
        vt.push_back('{1'b1, 1'b0, SW_INC,           1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h02});
        vt.push_back('{1'b1, 1'b0, SW_INC,           1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h03});
        vt.push_back('{1'b1, 1'b0, SW_INC,           1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h04});
        vt.push_back('{1'b1, 1'b0, SW_INC,           1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h05});
        vt.push_back('{1'b1, 1'b0, SW_NEXT,          1'b0, 1'b0, 2'd1, 8'h00, 8'h00, 8'h05});
        vt.push_back('{1'b1, 1'b0, SW_INC,           1'b0, 1'b0, 2'd1, 8'h00, 8'h01, 8'h05});
        vt.push_back('{1'b1, 1'b0, SW_INC,           1'b0, 1'b0, 2'd1, 8'h00, 8'h02, 8'h05});
        vt.push_back('{1'b0, 1'b1, SW_NONE,          1'b0, 1'b0, 2'd1, 8'h00, 8'h02, 8'h05});
        vt.push_back('{1'b0, 1'b0, SW_INC,           1'b0, 1'b0, 2'd1, 8'h00, 8'h02, 8'h05});
        vt.push_back('{1'b1, 1'b0, SW_NEXT,          1'b0, 1'b0, 2'd2, 8'h00, 8'h02, 8'h05});
        vt.push_back('{1'b1, 1'b0, SW_DEC,           1'b0, 1'b0, 2'd2, 8'h23, 8'h02, 8'h05});
        vt.push_back('{1'b1, 1'b0, SW_DEC,           1'b0, 1'b0, 2'd2, 8'h22, 8'h02, 8'h05});
        vt.push_back('{1'b1, 1'b0, SW_INC,           1'b0, 1'b0, 2'd2, 8'h23, 8'h02, 8'h05});
        vt.push_back('{1'b1, 1'b0, SW_INC,           1'b0, 1'b0, 2'd2, 8'h00, 8'h02, 8'h05});
        vt.push_back('{1'b1, 1'b0, SW_NEXT,          1'b0, 1'b0, 2'd0, 8'h00, 8'h02, 8'h05});
        vt.push_back('{1'b1, 1'b0, SW_DEC,           1'b0, 1'b0, 2'd0, 8'h00, 8'h02, 8'h04});
        vt.push_back('{1'b1, 1'b0, SW_INC | SW_DEC,  1'b0, 1'b0, 2'd0, 8'h00, 8'h02, 8'h05});
        vt.push_back('{1'b1, 1'b0, SW_CLR | SW_NEXT, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00});
        vt.push_back('{1'b1, 1'b0, SW_SS,            1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00});
        vt.push_back('{1'b1, 1'b0, SW_NEXT,          1'b0, 1'b0, 2'd1, 8'h00, 8'h00, 8'h00});

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].set, vt[i].en, vt[i].sw);
            chk_all($sformatf("vec%0d", i), vt[i].run, vt[i].alm, vt[i].fs, vt[i].h, vt[i].m, vt[i].s);
        end

        // one minute down to the alarm
        cmd(SW_INC);
        chk_all("pre1m", 1'b0, 1'b0, 2'd1, 8'h00, 8'h01, 8'h00);
        cmd(SW_SS);
        chk_all("start1m", 1'b1, 1'b0, 2'd1, 8'h00, 8'h01, 8'h00);
        ticks(1);
        chk_all("tick1", 1'b1, 1'b0, 2'd1, 8'h00, 8'h00, 8'h59);
        ticks(58);
        chk_all("tick59", 1'b1, 1'b0, 2'd1, 8'h00, 8'h00, 8'h01);
        ticks(1);
        chk_all("done1m", 1'b0, 1'b1, 2'd1, 8'h00, 8'h00, 8'h00);
        cmd(SW_CLR);
        chk_all("ack_clr", 1'b0, 1'b0, 2'd0, 8'h00, 8'h01, 8'h00);

        // hour borrow, then pause/resume with a colliding tick
        cmd(SW_CLR);
        cmd(SW_NEXT);
        cmd(SW_NEXT);
        cmd(SW_INC);
        chk_all("pre1h", 1'b0, 1'b0, 2'd2, 8'h01, 8'h00, 8'h00);
        cmd(SW_SS);
        ticks(1);
        chk_all("borrow", 1'b1, 1'b0, 2'd2, 8'h00, 8'h59, 8'h59);
        step(1'b1, 1'b1, SW_SS);
        chk_all("pause_collide", 1'b0, 1'b0, 2'd2, 8'h00, 8'h59, 8'h59);
        ticks(3);
        chk_all("pause_frozen", 1'b0, 1'b0, 2'd2, 8'h00, 8'h59, 8'h59);
        cmd(SW_SS);
        chk_all("resume", 1'b1, 1'b0, 2'd2, 8'h00, 8'h59, 8'h59);
        ticks(1);
        chk_all("resume_tick", 1'b1, 1'b0, 2'd2, 8'h00, 8'h59, 8'h58);
        cmd(SW_INC);
        chk_all("run_inc_ignored", 1'b1, 1'b0, 2'd2, 8'h00, 8'h59, 8'h58);
        cmd(SW_CLR);
        chk_all("run_clr", 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);

        // alarm timeout after 30 ticks
        cmd(SW_INC);
        cmd(SW_INC);
        cmd(SW_INC);
        cmd(SW_SS);
        ticks(3);
        chk_all("done3", 1'b0, 1'b1, 2'd0, 8'h00, 8'h00, 8'h00);
        ticks(29);
        chk_all("alarm29", 1'b0, 1'b1, 2'd0, 8'h00, 8'h00, 8'h00);
        ticks(1);
        chk_all("alarm30", 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h03);

        // early acknowledge with an increment command
        cmd(SW_SS);
        ticks(3);
        chk_all("done3b", 1'b0, 1'b1, 2'd0, 8'h00, 8'h00, 8'h00);
        ticks(2);
        chk_all("alarm2", 1'b0, 1'b1, 2'd0, 8'h00, 8'h00, 8'h00);
        cmd(SW_INC);
        chk_all("ack_inc", 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h03);

        // asynchronous reset while running at 00:10:07
        repeat (4) cmd(SW_INC);
        cmd(SW_NEXT);
        repeat (10) cmd(SW_INC);
        cmd(SW_SS);
        chk_all("run_10_07", 1'b1, 1'b0, 2'd1, 8'h00, 8'h10, 8'h07);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        ticks(2);
        chk_all("post_rst", 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
